// File: rtl/program_loader.sv
// program_loader: packs decoded instruction fields into 23-bit words and
// writes them to consecutive instruction-memory addresses from 0, holding
// the CPU for the duration of the load. A small show-ahead FIFO sits between
// the field handshake and the memory write port.
module program_loader #(
  parameter int MEM_DEPTH  = 11,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        in_opcode,
  input  logic [1:0]        in_regd,
  input  logic [1:0]        in_regs,
  input  logic [1:0]        in_regt,
  input  logic [11:0]       in_offset,
  output logic              mem_we,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [22:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]  FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] MAX_CNT   = (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [22:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_fifo_cnt;
  logic [ADDR_W:0]   r_acc_cnt;
  logic [ADDR_W:0]   r_word_cnt;
  logic [ADDR_W-1:0] r_addr;

  logic w_empty;
  logic w_full;
  logic w_start_ok;
  logic w_in_ready;
  logic w_accept;
  logic w_overflow;
  logic w_push;
  logic w_pop;

  assign w_empty    = (r_fifo_cnt == '0);
  assign w_full     = (r_fifo_cnt == FIFO_FULL);
  // start only opens a session from a quiescent state; LOAD/DRAIN ignore it
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                (r_state == S_ERROR));
  assign w_accept   = in_valid && w_in_ready;
  // A bundle beyond the memory capacity is swallowed and flags the error
  assign w_overflow = w_accept && (r_acc_cnt == MAX_CNT);
  assign w_push     = w_accept && !w_overflow;
  assign w_pop      = !w_empty && mem_wready;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_overflow)             w_state_next = S_ERROR;
        else if (w_push && in_last) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_empty) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state; in_ready ignores same-cycle pops
  always_comb begin
    w_in_ready = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_in_ready = !w_full;
        cpu_hold   = 1'b1;
      end
      S_DRAIN: cpu_hold = 1'b1;
      S_DONE:  done     = 1'b1;
      S_ERROR: begin
        cpu_hold = 1'b1;
        error    = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_ready   = w_in_ready;
  assign mem_we     = !w_empty;
  // Head word is shown directly; zero while nothing is queued
  assign mem_wdata  = w_empty ? 23'd0 : r_fifo[r_rd_ptr];
  assign mem_addr   = r_addr;
  assign word_count = r_word_cnt;

  // FIFO storage: encoded word captured on the accepting edge
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {in_opcode, in_regd, in_regs, in_regt, in_offset};
    end
  end

  // FIFO pointers, occupancy, accept counter and write-address/word counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_acc_cnt  <= '0;
      r_word_cnt <= '0;
      r_addr     <= '0;
    end else if (w_start_ok) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_acc_cnt  <= '0;
      r_word_cnt <= '0;
      r_addr     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_acc_cnt <= r_acc_cnt + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_addr     <= r_addr + 1'b1;
        r_word_cnt <= r_word_cnt + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed load sessions against a
// behavioural model that tracks accepted words in a queue; a negedge monitor
// compares DUT status every cycle and every memory write against it.
module tb_program_loader;

  localparam int MEM_DEPTH  = 11;
  localparam int ADDR_W     = 4;
  localparam int FIFO_DEPTH = 2;

  logic              clock;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [4:0]        in_opcode;
  logic [1:0]        in_regd;
  logic [1:0]        in_regs;
  logic [1:0]        in_regt;
  logic [11:0]       in_offset;
  logic              mem_we;
  logic              mem_wready;
  logic [ADDR_W-1:0] mem_addr;
  logic [22:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  program_loader #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_opcode (in_opcode),
    .in_regd   (in_regd),
    .in_regs   (in_regs),
    .in_regt   (in_regt),
    .in_offset (in_offset),
    .mem_we    (mem_we),
    .mem_wready(mem_wready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int wr_mode     = 0;   // 0: always ready, 1: random, 2: stalled

  // Behavioural model of one load session
  logic [22:0]     exp_q[$];
  bit              m_loading, m_draining, m_hold, m_done, m_err;
  int              m_accepted;
  logic [ADDR_W:0] m_written;

  // Monitor + model: compare the current cycle, then advance by the coming edge
  always @(negedge clock) begin
    logic [36:0] act, exp;
    logic [22:0] exp_data;
    bit          exp_ready, exp_we, honour_start, drain_fin;
    int          pre_size;
    if (reset) begin
      exp_q.delete();
      m_loading = 0; m_draining = 0; m_hold = 0; m_done = 0; m_err = 0;
      m_accepted = 0; m_written = '0;
    end
    pre_size  = exp_q.size();
    exp_we    = (pre_size > 0);
    exp_ready = m_loading && (pre_size < FIFO_DEPTH);
    exp_data  = exp_we ? exp_q[0] : 23'd0;
    act = {in_ready, mem_we, cpu_hold, done, error, mem_addr, word_count, mem_wdata};
    exp = {exp_ready, exp_we, m_hold, m_done, m_err, m_written[ADDR_W-1:0], m_written, exp_data};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL status t=%0t rdy/we/hold/done/err/addr/cnt/data got %b%b%b%b%b %0d %0d %h want %b%b%b%b%b %0d %0d %h",
               $time, in_ready, mem_we, cpu_hold, done, error, mem_addr, word_count, mem_wdata,
               exp_ready, exp_we, m_hold, m_done, m_err, m_written[ADDR_W-1:0], m_written, exp_data);
    end
    if (!reset) begin
      honour_start = start && !m_loading && !m_draining;
      drain_fin    = m_draining && (pre_size == 0);
      if (honour_start) begin
        exp_q.delete();
        m_loading = 1; m_draining = 0; m_hold = 1; m_done = 0; m_err = 0;
        m_accepted = 0; m_written = '0;
      end else begin
        if (exp_we && mem_wready) begin
          vectors++;
          if (mem_we !== 1'b1 || mem_addr !== m_written[ADDR_W-1:0] || mem_wdata !== exp_q[0]) begin
            miscompares++;
            $display("FAIL write got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                     mem_we, mem_addr, mem_wdata, m_written[ADDR_W-1:0], exp_q[0]);
          end else begin
            $display("write addr=%0d data=%h", mem_addr, mem_wdata);
          end
          void'(exp_q.pop_front());
          m_written = m_written + 1'b1;
        end
        if (in_valid && exp_ready) begin
          if (m_accepted == MEM_DEPTH) begin
            m_loading = 0;
            m_err     = 1;
          end else begin
            exp_q.push_back({in_opcode, in_regd, in_regs, in_regt, in_offset});
            m_accepted++;
            if (in_last) begin
              m_loading  = 0;
              m_draining = 1;
            end
          end
        end
        if (drain_fin) begin
          m_draining = 0;
          m_done     = 1;
          m_hold     = 0;
        end
      end
    end
  end

  // Memory backpressure driver
  initial begin
    mem_wready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (wr_mode)
        0:       mem_wready = 1'b1;
        1:       mem_wready = ($urandom_range(0, 3) != 0);
        default: mem_wready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic [1:0] rt, input logic [11:0] off, input logic last);
    bit got;
    got = 0;
    in_valid = 1'b1; in_opcode = op; in_regd = rd; in_regs = rs; in_regt = rt;
    in_offset = off; in_last = last;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      got = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout in_ready stayed %b want 1", in_ready);
    end
  endtask

  task automatic send_rand(input logic last);
    logic [4:0]  op;
    logic [1:0]  rd, rs, rt;
    logic [11:0] off;
    op  = 5'($urandom);  rd = 2'($urandom); rs = 2'($urandom); rt = 2'($urandom);
    off = 12'($urandom);
    repeat ($urandom_range(0, 2)) tick();
    send(op, rd, rs, rt, off, last);
  endtask

  task automatic wait_end();
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      seen = done || error;
    end
    tick();
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL session_end_timeout done=%b error=%b want one of them 1", done, error);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_opcode = '0; in_regd = '0; in_regs = '0; in_regt = '0; in_offset = '0;
    @(negedge clock);
    tick();
    reset = 1'b0;
    tick();

    // Four-word program with free-running memory
    wr_mode = 0;
    pulse_start();
    for (int i = 0; i < 4; i++) send(5'b00010, 2'b01, 2'b00, 2'b00, 12'(i + 1), i == 3);
    wait_end();
    check("four_word_count", 32'(word_count), 32'd4);
    check("four_word_done_hold", {30'd0, done, cpu_hold}, 32'b10);

    // Backpressure: stall memory after the first write, FIFO fills at two entries
    pulse_start();
    send_rand(1'b0);
    repeat (3) tick();
    wr_mode = 2;
    tick();
    send_rand(1'b0);
    send_rand(1'b0);
    @(negedge clock);
    check("stall_ready_we", {30'd0, in_ready, mem_we}, 32'b01);
    repeat (5) tick();
    wr_mode = 0;
    send_rand(1'b0);
    send_rand(1'b1);
    wait_end();
    check("stall_count", 32'(word_count), 32'd5);

    // Overflow: twelve bundles with no last
    pulse_start();
    for (int i = 0; i < 12; i++) send_rand(1'b0);
    wait_end();
    repeat (4) tick();
    check("ovf_count", 32'(word_count), 32'd11);
    check("ovf_err_done_hold", {29'd0, error, done, cpu_hold}, 32'b101);

    // Exactly full program
    pulse_start();
    for (int i = 0; i < 11; i++) send_rand(i == 10);
    wait_end();
    check("full_count", 32'(word_count), 32'd11);
    check("full_err_done", {30'd0, error, done}, 32'b01);

    // Asynchronous reset mid-load after two writes
    pulse_start();
    send_rand(1'b0);
    send_rand(1'b0);
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
        @(negedge clock);
        hit = (word_count == 2);
      end
      check("pre_reset_count", 32'(word_count), 32'd2);
    end
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs",
          {in_ready, mem_we, cpu_hold, done, error, 1'b0, mem_addr, word_count, 3'd0},
          32'd0);
    check("async_reset_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clock);
    tick();
    reset = 1'b0;
    tick();
    pulse_start();
    send_rand(1'b0);
    send_rand(1'b1);
    wait_end();
    check("post_reset_count", 32'(word_count), 32'd2);

    // start during DRAIN is ignored; a later start clears done
    wr_mode = 2;
    tick();
    pulse_start();
    send_rand(1'b0);
    send_rand(1'b1);
    pulse_start();
    repeat (3) tick();
    check("drain_hold", {31'd0, cpu_hold}, 32'd1);
    wr_mode = 0;
    wait_end();
    check("drain_done", {31'd0, done}, 32'd1);
    pulse_start();
    @(negedge clock);
    check("restart_clears_done", {30'd0, done, cpu_hold}, 32'b01);
    tick();
    send_rand(1'b1);
    wait_end();

    // Randomized sessions
    wr_mode = 1;
    for (int s = 0; s < 20; s++) begin
      n = $urandom_range(1, 12);
      pulse_start();
      for (int i = 0; i < n; i++) send_rand((n <= MEM_DEPTH) && (i == n - 1));
      wait_end();
      repeat (6) tick();
    end

    wr_mode = 0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
